// File: rtl/feedback_pkg.sv
// rtl/feedback_pkg.sv - shared types, field map and decode helper for the controller feedback driver
//
// Purpose: one place for the FSM encoding, the MMIO command word field map
//          and the status word bit positions used by controller_feedback_driver.
// Ports:   none (package).

package feedback_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } feedbackState_t;

    // Command word field map
    localparam int CMD_GO_BIT        = 0;
    localparam int CMD_ABORT_BIT     = 1;
    localparam int CMD_COUNT_LSB     = 4;
    localparam int CMD_COUNT_W       = 4;
    localparam int CMD_ON_LSB        = 8;
    localparam int CMD_ON_W          = 8;
    localparam int CMD_OFF_LSB       = 16;
    localparam int CMD_OFF_W         = 8;
    localparam int CMD_INTENSITY_LSB = 24;
    localparam int CMD_INTENSITY_W   = 4;

    // Status word bit positions
    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_PULSES_LSB  = 1;
    localparam int STATUS_PULSES_W    = 4;

    typedef struct packed {
        logic [CMD_COUNT_W-1:0]     count;
        logic [CMD_ON_W-1:0]        onUnits;
        logic [CMD_OFF_W-1:0]       offUnits;
        logic [CMD_INTENSITY_W-1:0] intensity;
    } feedbackCmd_t;

    function automatic feedbackCmd_t decodeCmd(input logic [31:0] word);
        feedbackCmd_t cmd;
        cmd.count     = word[CMD_COUNT_LSB     +: CMD_COUNT_W];
        cmd.onUnits   = word[CMD_ON_LSB        +: CMD_ON_W];
        cmd.offUnits  = word[CMD_OFF_LSB       +: CMD_OFF_W];
        cmd.intensity = word[CMD_INTENSITY_LSB +: CMD_INTENSITY_W];
        return cmd;
    endfunction

endpackage

// File: rtl/controller_feedback_driver_if.sv
// rtl/controller_feedback_driver_if.sv - MMIO-side bundle between the CPU write path and the feedback driver
//
// Purpose: groups the MMIO command/status signals of one player's feedback driver.
// Signals:
//   mmioWrite        CPU -> driver  one-cycle write strobe
//   mmioBoardOutput  CPU -> driver  32-bit command word
//   mmioStatus       driver -> CPU  [0]=busy, [4:1]=pulses remaining
//   doneStrobe       driver -> CPU  one-cycle pulse on normal pattern completion
// Modports: master (CPU side), slave (driver side).

interface controller_feedback_driver_if;

    logic        mmioWrite;
    logic [31:0] mmioBoardOutput;
    logic [31:0] mmioStatus;
    logic        doneStrobe;

    modport master (
        output mmioWrite,
        output mmioBoardOutput,
        input  mmioStatus,
        input  doneStrobe
    );

    modport slave (
        input  mmioWrite,
        input  mmioBoardOutput,
        output mmioStatus,
        output doneStrobe
    );

endinterface

// File: rtl/unit_tick_prescaler.sv
// rtl/unit_tick_prescaler.sv - divides fastClock down to one tick per time unit
//
// Purpose: while enabled, produces a one-cycle tick every UNIT_CYCLES cycles;
//          clear restarts the count so the first tick lands UNIT_CYCLES cycles later.
// Ports:
//   fastClock  in   clock
//   reset      in   synchronous active-high reset
//   clear      in   restart the prescaler (wins over enable)
//   enable     in   count this cycle
//   tick       out  high on the last cycle of each unit

module unit_tick_prescaler #(
    parameter int UNIT_CYCLES = 500000
) (
    input  logic fastClock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(UNIT_CYCLES - 1);

    logic [CNT_W-1:0] prescaleCnt;

    always_ff @(posedge fastClock) begin
        if (reset || clear) begin
            prescaleCnt <= '0;
        end else if (enable) begin
            prescaleCnt <= (prescaleCnt == LAST_COUNT) ? '0 : prescaleCnt + 1'b1;
        end
    end

    // Tick is not masked by clear: the owner clears on the very tick that ends a timer.
    assign tick = enable && (prescaleCnt == LAST_COUNT);

endmodule

// File: rtl/controller_feedback_driver.sv
// rtl/controller_feedback_driver.sv - plays LED/rumble pulse trains commanded over MMIO
//
// Purpose: latches a pulse-train command (count, on-time, off-time, intensity)
//          written over MMIO, plays it on ledMotorOut and reports busy status.
// Ports:
//   fastClock    in      sole clock
//   reset        in      synchronous active-high reset
//   mmio         slave   MMIO bundle: mmioWrite, mmioBoardOutput in; mmioStatus, doneStrobe out
//   ledMotorOut  out     registered LED/rumble drive
// Build option: FEEDBACK_PWM_EN - when defined, the ON level is PWM-gated by the
//               latched intensity; otherwise ON is a constant high.

module controller_feedback_driver
    import feedback_pkg::*;
#(
    parameter int UNIT_CYCLES = 500000,
    parameter int PWM_BITS    = 4
) (
    input  logic                          fastClock,
    input  logic                          reset,
    controller_feedback_driver_if.slave   mmio,
    output logic                          ledMotorOut
);

    feedbackState_t state;
    feedbackState_t nextState;

    feedbackCmd_t   newCmd;
    feedbackCmd_t   curCmd;
    logic [3:0]     pulsesLeft;
    logic [7:0]     unitCnt;
    logic           unitTick;

    logic           goValid;
    logic           abortValid;
    logic           expire;
    logic [7:0]     onLast;
    logic [7:0]     offLast;

    logic           timerClear;
    logic           loadCmd;
    logic           decPulse;

    logic           ledNext;
    logic           doneNext;
    logic           pwmGate;

    logic           doneReg;
    logic [31:0]    statusReg;

    logic           unusedCmdBits;

    assign newCmd        = decodeCmd(mmio.mmioBoardOutput);
    assign unusedCmdBits = ^{mmio.mmioBoardOutput[31:28], mmio.mmioBoardOutput[3:2]};

    // Abort beats go; go with a zero count is not a command at all.
    assign abortValid = mmio.mmioWrite && mmio.mmioBoardOutput[CMD_ABORT_BIT];
    assign goValid    = mmio.mmioWrite && mmio.mmioBoardOutput[CMD_GO_BIT]
                        && (newCmd.count != '0) && !abortValid;

    // Timers end on the tick where the unit counter reaches length-1; zero on-units acts as one.
    assign onLast  = (curCmd.onUnits == 8'd0) ? 8'd0 : curCmd.onUnits - 8'd1;
    assign offLast = curCmd.offUnits - 8'd1;
    assign expire  = unitTick && (((state == ON)  && (unitCnt == onLast)) ||
                                  ((state == OFF) && (unitCnt == offLast)));

    unit_tick_prescaler #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_prescaler (
        .fastClock (fastClock),
        .reset     (reset),
        .clear     (timerClear),
        .enable    (state != IDLE),
        .tick      (unitTick)
    );

    // State register
    always_ff @(posedge fastClock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic. Every state entry (including a merged ON restart) clears the timers.
    always_comb begin
        nextState  = state;
        timerClear = (state == IDLE);
        loadCmd    = 1'b0;
        decPulse   = 1'b0;
        if (abortValid) begin
            nextState  = IDLE;
            timerClear = 1'b1;
        end else if (goValid) begin
            nextState  = ON;
            timerClear = 1'b1;
            loadCmd    = 1'b1;
        end else if (expire) begin
            timerClear = 1'b1;
            if (state == ON) begin
                if (pulsesLeft == 4'd1) begin
                    nextState = IDLE;
                end else begin
                    decPulse  = 1'b1;
                    nextState = (curCmd.offUnits != 8'd0) ? OFF : ON;
                end
            end else begin
                nextState = ON;
            end
        end
    end

    // Command latch, pulse counter and unit counter
    always_ff @(posedge fastClock) begin
        if (reset) begin
            curCmd     <= '0;
            pulsesLeft <= 4'd0;
            unitCnt    <= 8'd0;
        end else begin
            if (loadCmd) begin
                curCmd     <= newCmd;
                pulsesLeft <= newCmd.count;
            end else if (nextState == IDLE) begin
                pulsesLeft <= 4'd0;
            end else if (decPulse) begin
                pulsesLeft <= pulsesLeft - 4'd1;
            end

            if (timerClear) begin
                unitCnt <= 8'd0;
            end else if (unitTick) begin
                unitCnt <= unitCnt + 8'd1;
            end
        end
    end

`ifdef FEEDBACK_PWM_EN
    logic [PWM_BITS-1:0]        pwmCnt;
    logic [CMD_INTENSITY_W-1:0] intensitySel;

    always_ff @(posedge fastClock) begin
        if (reset) begin
            pwmCnt <= '0;
        end else begin
            pwmCnt <= pwmCnt + 1'b1;
        end
    end

    // The output is registered from the next state, so use the intensity that will be current then.
    assign intensitySel = loadCmd ? newCmd.intensity : curCmd.intensity;
    assign pwmGate      = (pwmCnt <= PWM_BITS'(intensitySel));
`else
    localparam int unusedPwmBits = PWM_BITS;
    logic          unusedIntensity;

    assign unusedIntensity = ^curCmd.intensity;
    assign pwmGate         = 1'b1;
`endif

    // Output logic: done only on a natural final expiry that no write overrides.
    always_comb begin
        ledNext  = (nextState == ON) && pwmGate;
        doneNext = expire && (state == ON) && (pulsesLeft == 4'd1)
                   && !abortValid && !goValid;
    end

    // Output registers; status follows the registered state, hence one cycle behind it.
    always_ff @(posedge fastClock) begin
        if (reset) begin
            ledMotorOut <= 1'b0;
            doneReg     <= 1'b0;
            statusReg   <= 32'd0;
        end else begin
            ledMotorOut <= ledNext;
            doneReg     <= doneNext;
            statusReg   <= 32'd0;
            statusReg[STATUS_BUSY_BIT]                       <= (state != IDLE);
            statusReg[STATUS_PULSES_LSB +: STATUS_PULSES_W]  <= pulsesLeft;
        end
    end

    assign mmio.doneStrobe = doneReg;
    assign mmio.mmioStatus = statusReg;

endmodule

// File: tb/tb_controller_feedback_driver.sv
// tb/tb_controller_feedback_driver.sv - scoreboard bench for controller_feedback_driver

module tb_controller_feedback_driver;

    localparam int KLED  = 0;
    localparam int KDONE = 1;
    localparam int KSTAT = 2;
    localparam int KHIGH = 3;

`ifdef FEEDBACK_PWM_EN
    localparam int HIGH_I7 = 8;
    localparam int HIGH_I0 = 1;
`else
    localparam int HIGH_I7 = 16;
    localparam int HIGH_I0 = 16;
`endif

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
        string       name;
    } expect_t;

    logic fastClock;
    logic reset;
    logic ledMotorOut;
    int   cyc;
    int   checks;
    int   passes;
    bit   ledHist [0:4095];

    expect_t sbq[$];

    controller_feedback_driver_if bus();

    controller_feedback_driver #(
        .UNIT_CYCLES (10),
        .PWM_BITS    (4)
    ) dut (
        .fastClock   (fastClock),
        .reset       (reset),
        .mmio        (bus),
        .ledMotorOut (ledMotorOut)
    );

    initial begin
        fastClock = 1'b0;
        forever #5 fastClock = ~fastClock;
    end

    initial cyc = 0;
    always @(posedge fastClock) cyc <= cyc + 1;

    function automatic logic [31:0] cmdWord(input bit go, input bit ab, input int cnt,
                                            input int on, input int off, input int inten);
        logic [31:0] w;
        w        = '0;
        w[0]     = go;
        w[1]     = ab;
        w[7:4]   = cnt[3:0];
        w[15:8]  = on[7:0];
        w[23:16] = off[7:0];
        w[27:24] = inten[3:0];
        return w;
    endfunction

    task automatic pushSeg(input int first, input int last, input int kind,
                           input logic [31:0] val, input string name);
        for (int c = first; c <= last; c++) begin
            sbq.push_back('{cyc: c, kind: kind, val: val, name: name});
        end
    endtask

    task automatic waitCyc(input int target);
        while (cyc < target) begin
            @(posedge fastClock);
            #1;
        end
    endtask

    task automatic issue(input logic [31:0] word, input logic wr, output int n);
        n                    = cyc;
        bus.mmioWrite        = wr;
        bus.mmioBoardOutput  = word;
        @(posedge fastClock);
        #1;
        bus.mmioWrite        = 1'b0;
        bus.mmioBoardOutput  = '0;
    endtask

    // Monitor: compares every expectation that falls due in the current cycle.
    initial begin
        checks = 0;
        passes = 0;
        forever begin
            @(negedge fastClock);
            ledHist[cyc[11:0]] = ledMotorOut;
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].cyc == cyc) begin
                    logic [31:0] act;
                    int          highs;
                    case (sbq[i].kind)
                        KLED:    act = {31'd0, ledMotorOut};
                        KDONE:   act = {31'd0, bus.doneStrobe};
                        KSTAT:   act = bus.mmioStatus;
                        default: begin
                            highs = 0;
                            for (int k = 0; k < 16; k++) begin
                                highs += int'(ledHist[(cyc - k) & 4095]);
                            end
                            act = highs;
                        end
                    endcase
                    checks++;
                    if (act === sbq[i].val) begin
                        passes++;
                    end else begin
                        $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                                 sbq[i].name, cyc, act, sbq[i].val);
                    end
                    sbq.delete(i);
                end else if (sbq[i].cyc < cyc) begin
                    checks++;
                    $display("FAIL %s stale expectation cyc=%0d actual=none required=checked",
                             sbq[i].name, sbq[i].cyc);
                    sbq.delete(i);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        int x;
        reset               = 1'b1;
        bus.mmioWrite       = 1'b0;
        bus.mmioBoardOutput = '0;

        // Reset state
        pushSeg(1, 5, KLED,  0, "rst_led");
        pushSeg(1, 5, KDONE, 0, "rst_done");
        pushSeg(1, 5, KSTAT, 0, "rst_status");
        waitCyc(4);
        reset = 1'b0;
        waitCyc(6);

        // 1: basic pattern count=3 on=2 off=1
        issue(cmdWord(1, 0, 3, 2, 1, 15), 1'b1, n);
        pushSeg(n+1,  n+20, KLED, 1, "t1_on1");
        pushSeg(n+21, n+30, KLED, 0, "t1_off1");
        pushSeg(n+31, n+50, KLED, 1, "t1_on2");
        pushSeg(n+51, n+60, KLED, 0, "t1_off2");
        pushSeg(n+61, n+80, KLED, 1, "t1_on3");
        pushSeg(n+81, n+85, KLED, 0, "t1_idle");
        pushSeg(n+1,  n+80, KDONE, 0, "t1_nodone");
        pushSeg(n+81, n+81, KDONE, 1, "t1_done");
        pushSeg(n+82, n+85, KDONE, 0, "t1_doneonce");
        pushSeg(n+1,  n+1,  KSTAT, 0, "t1_stat_lag");
        pushSeg(n+2,  n+21, KSTAT, 32'h7, "t1_stat3");
        pushSeg(n+22, n+51, KSTAT, 32'h5, "t1_stat2");
        pushSeg(n+52, n+81, KSTAT, 32'h3, "t1_stat1");
        pushSeg(n+82, n+85, KSTAT, 0, "t1_stat_idle");
        waitCyc(n+86);

        // 2: latency and status, count=1 on=1
        issue(cmdWord(1, 0, 1, 1, 0, 15), 1'b1, n);
        pushSeg(n+1,  n+10, KLED, 1, "t2_on");
        pushSeg(n+11, n+14, KLED, 0, "t2_off");
        pushSeg(n+1,  n+10, KDONE, 0, "t2_nodone");
        pushSeg(n+11, n+11, KDONE, 1, "t2_done");
        pushSeg(n+12, n+14, KDONE, 0, "t2_doneonce");
        pushSeg(n+1,  n+1,  KSTAT, 0, "t2_stat_lag");
        pushSeg(n+2,  n+11, KSTAT, 32'h3, "t2_stat_busy");
        pushSeg(n+12, n+14, KSTAT, 0, "t2_stat_idle");
        waitCyc(n+15);

        // 3: abort at cycle 5 of count=3 on=4, then go+abort together
        issue(cmdWord(1, 0, 3, 4, 1, 15), 1'b1, n);
        pushSeg(n+1, n+5,  KLED, 1, "t3_on");
        pushSeg(n+6, n+50, KLED, 0, "t3_aborted");
        pushSeg(n+1, n+50, KDONE, 0, "t3_nodone");
        pushSeg(n+2, n+6,  KSTAT, 32'h7, "t3_stat_busy");
        pushSeg(n+7, n+50, KSTAT, 0, "t3_stat_idle");
        waitCyc(n+5);
        issue(cmdWord(0, 1, 0, 0, 0, 0), 1'b1, x);
        waitCyc(n+51);
        issue(cmdWord(1, 1, 2, 1, 0, 15), 1'b1, m);
        pushSeg(m+1, m+15, KLED,  0, "t3_goabort_led");
        pushSeg(m+1, m+15, KDONE, 0, "t3_goabort_done");
        pushSeg(m+1, m+15, KSTAT, 0, "t3_goabort_stat");
        waitCyc(m+16);

        // 4: retrigger mid-OFF, then go count=0 and an unstrobed command
        issue(cmdWord(1, 0, 4, 1, 3, 15), 1'b1, n);
        pushSeg(n+1,  n+10, KLED, 1, "t4_first_on");
        pushSeg(n+11, n+15, KLED, 0, "t4_first_off");
        pushSeg(n+1,  n+15, KDONE, 0, "t4_first_nodone");
        pushSeg(n+2,  n+11, KSTAT, 32'h9, "t4_stat4");
        pushSeg(n+12, n+16, KSTAT, 32'h7, "t4_stat3");
        waitCyc(n+15);
        issue(cmdWord(1, 0, 2, 3, 1, 15), 1'b1, m);
        pushSeg(m+1,  m+30, KLED, 1, "t4_retrig_on");
        pushSeg(m+31, m+40, KLED, 0, "t4_retrig_off");
        pushSeg(m+41, m+70, KLED, 1, "t4_retrig_on2");
        pushSeg(m+71, m+74, KLED, 0, "t4_idle");
        pushSeg(m+1,  m+70, KDONE, 0, "t4_nodone");
        pushSeg(m+71, m+71, KDONE, 1, "t4_done");
        pushSeg(m+72, m+74, KDONE, 0, "t4_doneonce");
        pushSeg(m+2,  m+31, KSTAT, 32'h5, "t4_stat_retrig");
        pushSeg(m+32, m+71, KSTAT, 32'h3, "t4_stat1");
        pushSeg(m+72, m+74, KSTAT, 0, "t4_stat_idle");
        waitCyc(m+20);
        issue(cmdWord(1, 0, 0, 5, 0, 15), 1'b1, x);
        waitCyc(m+25);
        issue(cmdWord(1, 1, 3, 2, 2, 15), 1'b0, x);
        waitCyc(m+75);

        // 5: merged pulses (off=0), then reset mid-ON
        issue(cmdWord(1, 0, 2, 1, 0, 15), 1'b1, n);
        pushSeg(n+1,  n+20, KLED, 1, "t5_merged");
        pushSeg(n+21, n+24, KLED, 0, "t5_idle");
        pushSeg(n+1,  n+20, KDONE, 0, "t5_nodone");
        pushSeg(n+21, n+21, KDONE, 1, "t5_done");
        pushSeg(n+22, n+24, KDONE, 0, "t5_doneonce");
        pushSeg(n+1,  n+1,  KSTAT, 0, "t5_stat_lag");
        pushSeg(n+2,  n+11, KSTAT, 32'h5, "t5_stat2");
        pushSeg(n+12, n+21, KSTAT, 32'h3, "t5_stat1");
        pushSeg(n+22, n+24, KSTAT, 0, "t5_stat_idle");
        waitCyc(n+25);
        issue(cmdWord(1, 0, 3, 5, 2, 15), 1'b1, n);
        pushSeg(n+1, n+7,  KLED, 1, "t5_pre_reset");
        pushSeg(n+8, n+30, KLED, 0, "t5_reset_led");
        pushSeg(n+1, n+30, KDONE, 0, "t5_reset_done");
        pushSeg(n+2, n+7,  KSTAT, 32'h7, "t5_pre_reset_stat");
        pushSeg(n+8, n+30, KSTAT, 0, "t5_reset_stat");
        waitCyc(n+7);
        reset = 1'b1;
        waitCyc(n+8);
        reset = 1'b0;
        waitCyc(n+31);

        // 6: intensity 7 and 0 duty over 16-cycle windows
        issue(cmdWord(1, 0, 1, 5, 0, 7), 1'b1, n);
        pushSeg(n+26, n+26, KHIGH, HIGH_I7, "t6_i7_win1");
        pushSeg(n+42, n+42, KHIGH, HIGH_I7, "t6_i7_win2");
        pushSeg(n+51, n+54, KLED, 0, "t6_i7_idle");
        pushSeg(n+51, n+51, KDONE, 1, "t6_i7_done");
        waitCyc(n+55);
        issue(cmdWord(1, 0, 1, 4, 0, 0), 1'b1, n);
        pushSeg(n+20, n+20, KHIGH, HIGH_I0, "t6_i0_win");
        pushSeg(n+41, n+43, KLED, 0, "t6_i0_idle");
        waitCyc(n+44);

        waitCyc(cyc + 2);
        checks++;
        if (sbq.size() == 0) begin
            passes++;
        end else begin
            $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
